dw_conv_pre_ctrl: RTL
=====================

Name: dw_conv_pre_ctrl

Overview:
Sequencing controller for the depthwise-conv preprocessing datapath (3-row line buffer plus 3x3 window generator). It latches per-layer feature-map geometry and programs the line-buffer length. It gates the pixel stream into the preprocessor and tracks row/column position. It emits a window-valid strobe, aligned to the window-generator output, that honours stride and drops edge windows, and signals frame completion.

Parameters:
DATA_WIDTH, 8, bits per channel element
OUT_CHANNEL_NUM, 18, channels packed per pixel beat
DIM_W, 9, width of the width/height config fields and the position counters
ROW_BUFFER_DEPTH, 9, width of buff_len_ctrl
WIN_LAT, 2, cycles from pp_valid to window present at window-generator output

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle layer start request; sampled only in IDLE
cfg_width  in  DIM_W  feature-map width in pixels, legal range 3..2^DIM_W-1
cfg_height  in  DIM_W  feature-map height in rows, legal range >=3
cfg_stride2  in  1  0 = stride 1, 1 = stride 2
in_data  in  OUT_CHANNEL_NUM*DATA_WIDTH  upstream pixel beat
in_valid  in  1  upstream beat valid
in_ready  out  1  controller accepts a beat
pp_data  out  OUT_CHANNEL_NUM*DATA_WIDTH  registered beat to preprocessor data_in
pp_valid  out  1  registered valid to preprocessor valid_in
buff_len_ctrl  out  ROW_BUFFER_DEPTH  line-buffer length, equal to cfg_width-3
buff_len_rst  out  1  one-cycle line-buffer pointer reset
win_valid  out  1  current window-generator output is a kept window
win_row  out  DIM_W  output-row index of the kept window
win_col  out  DIM_W  output-column index of the kept window
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after the last window is issued
cfg_err  out  1  one-cycle pulse on illegal config

Behaviour:
- Reset state: IDLE. All outputs 0, including pp_data. Counters and the delay line are cleared. Reset overrides everything, including mid-frame; no frame_done pulse is issued on reset.
- States: IDLE, CFG, RUN, DRAIN.
- IDLE:
  - in_ready=0.
  - start with cfg_width<3 or cfg_height<3: cfg_err=1 next cycle; stay in IDLE.
  - start with a legal config: latch W, H, stride; go to CFG.
- CFG (exactly 1 cycle):
  - buff_len_rst=1.
  - buff_len_ctrl <= W-3 (register holds this value until the next CFG).
  - row=0, col=0; go to RUN.
- RUN:
  - in_ready=1.
  - A beat is accepted when in_valid&in_ready.
  - Next cycle: pp_data <= in_data and pp_valid=1. Otherwise pp_valid=0; pp_data holds.
  - Per accepted beat: col++. At col==W-1, col wraps to 0 and row++.
  - Keep condition for the beat at (row,col): row>=2 && col>=2 && (!stride2 || (row[0]==0 && col[0]==0)).
  - Keep tag: win_row = stride2 ? (row-2)>>1 : row-2; win_col is formed the same way from col.
  - Keep/tag is pushed into a WIN_LAT+1 stage shift register alongside pp_valid. win_valid and the tags come out of the last stage, i.e. WIN_LAT cycles after pp_valid.
  - On accepting the beat at row==H-1, col==W-1: go to DRAIN; in_ready drops the next cycle.
  - start is ignored while not in IDLE.
  - in_valid gaps freeze the counters; the delay line still shifts, with zeros entering.
- DRAIN:
  - in_ready=0.
  - Counts WIN_LAT+1 cycles so the shift register empties.
  - On the final count: frame_done=1 for one cycle, then IDLE.
- Window count per frame: (W-2)*(H-2) for stride 1; ceil((W-2)/2)*ceil((H-2)/2) for stride 2.
- Width rules:
  - buff_len_ctrl is the truncated W-3.
  - Counters are DIM_W wide and never exceed W-1 or H-1.
  - No overflow is possible for legal configs.

Test Plan:
- Reset, then W=5, H=4, stride1, continuous valid, 20 beats -> buff_len_rst pulses once in CFG; buff_len_ctrl=2; 6 win_valid pulses. First pulse is WIN_LAT+1 cycles after beat index 12 is accepted, tagged (0,0); last tagged (1,2). frame_done follows WIN_LAT+1 cycles after the last beat.
- W=6, H=6, stride2, 36 beats -> exactly 4 win_valid pulses, tags (0,0), (0,1), (1,0), (1,1); none from odd rows or columns.
- W=5, H=4 with in_valid deasserted every other cycle -> same 6 windows and tags as scenario 1; each win_valid is exactly WIN_LAT cycles after its pp_valid.
- start with W=2, H=8 -> cfg_err pulse; busy stays 0; in_ready stays 0; buff_len_rst never asserts.
- Assert rst after 10 beats of a W=5 frame -> next cycle all outputs are 0 and busy=0; no frame_done. A new start runs a clean 6-window frame.
- start pulsed during RUN with a different config -> ignored; window count and buff_len_ctrl match the original config.

Source files
------------

// File: rtl/dw_conv_pre_ctrl.sv
// Sequencing controller for the depthwise-conv preprocessor: gates the pixel stream,
// programs the line buffer and marks which window-generator outputs are kept.
module dw_conv_pre_ctrl #(
  parameter int DATA_WIDTH       = 8,
  parameter int OUT_CHANNEL_NUM  = 18,
  parameter int DIM_W            = 9,
  parameter int ROW_BUFFER_DEPTH = 9,
  parameter int WIN_LAT          = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [DIM_W-1:0]                      cfg_width,
  input  logic [DIM_W-1:0]                      cfg_height,
  input  logic                                  cfg_stride2,
  input  logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] pp_data,
  output logic                                  pp_valid,
  output logic [ROW_BUFFER_DEPTH-1:0]           buff_len_ctrl,
  output logic                                  buff_len_rst,
  output logic                                  win_valid,
  output logic [DIM_W-1:0]                      win_row,
  output logic [DIM_W-1:0]                      win_col,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  cfg_err
);

  localparam int BEAT_W = OUT_CHANNEL_NUM * DATA_WIDTH;
  localparam int CNT_W  = $clog2(WIN_LAT + 1) + 1;
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO   = DIM_W'(2);
  localparam logic [DIM_W-1:0] THREE = DIM_W'(3);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WIN_LAT);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_RUN, S_DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [DIM_W-1:0]            w_q, h_q;
  logic                        s2_q;
  logic [DIM_W-1:0]            row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [BEAT_W-1:0]           pp_data_q;
  logic                        pp_valid_q;
  logic [ROW_BUFFER_DEPTH-1:0] blen_q;
  logic                        cfg_err_q;
  logic [WIN_LAT:0]            vld_q;
  logic [DIM_W-1:0]            wrow_q [WIN_LAT+1];
  logic [DIM_W-1:0]            wcol_q [WIN_LAT+1];

  logic accept, last_beat, keep, cfg_bad, push;

  // Output index of a kept window: offset past the 2-pixel border, halved for stride 2.
  function automatic logic [DIM_W-1:0] win_idx(input logic [DIM_W-1:0] pos, input logic s2);
    logic [DIM_W-1:0] off;
    off = pos - TWO;
    return s2 ? (off >> 1) : off;
  endfunction

  assign in_ready  = (state_q == S_RUN);
  assign accept    = in_ready & in_valid;
  assign last_beat = (row_q == h_q - ONE) && (col_q == w_q - ONE);
  assign cfg_bad   = (cfg_width < THREE) || (cfg_height < THREE);
  assign keep      = (row_q >= TWO) && (col_q >= TWO) && (!s2_q || (!row_q[0] && !col_q[0]));
  assign push      = accept & keep;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !cfg_bad) state_d = S_CFG;
      end
      S_CFG: begin
        row_d   = '0;
        col_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          if (last_beat) begin
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else if (col_q == w_q - ONE) begin
            col_d = '0;
            row_d = row_q + ONE;
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = S_IDLE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      s2_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      pp_data_q  <= '0;
      pp_valid_q <= 1'b0;
      blen_q     <= '0;
      cfg_err_q  <= 1'b0;
      vld_q      <= '0;
      for (int k = 0; k <= WIN_LAT; k++) begin
        wrow_q[k] <= '0;
        wcol_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= (state_q == S_IDLE) && start && cfg_bad;
      if (state_q == S_IDLE && start && !cfg_bad) begin
        w_q  <= cfg_width;
        h_q  <= cfg_height;
        s2_q <= cfg_stride2;
      end
      if (state_q == S_CFG) blen_q <= ROW_BUFFER_DEPTH'(w_q - THREE);
      // Stage 0: registered beat toward the preprocessor
      pp_valid_q <= accept;
      if (accept) pp_data_q <= in_data;
      // Stages 1..WIN_LAT: keep/tag delay matching the window generator
      vld_q     <= {vld_q[WIN_LAT-1:0], push};
      wrow_q[0] <= push ? win_idx(row_q, s2_q) : '0;
      wcol_q[0] <= push ? win_idx(col_q, s2_q) : '0;
      for (int k = 1; k <= WIN_LAT; k++) begin
        wrow_q[k] <= wrow_q[k-1];
        wcol_q[k] <= wcol_q[k-1];
      end
    end
  end

  assign pp_data       = pp_data_q;
  assign pp_valid      = pp_valid_q;
  assign buff_len_ctrl = blen_q;
  assign buff_len_rst  = (state_q == S_CFG);
  assign win_valid     = vld_q[WIN_LAT];
  assign win_row       = wrow_q[WIN_LAT];
  assign win_col       = wcol_q[WIN_LAT];
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DRAIN) && (cnt_q == DRAIN_LAST);
  assign cfg_err       = cfg_err_q;

endmodule
